uart_axil_bridge: RTL and testbench

// - AXI4-Lite slave front end for the UART register block. Converts AW/W/B and AR/R channels into

---
 rtl/uart_axil_bridge_if.sv | 74 +++++++
 rtl/uart_axil_bridge.sv | 277 +++++++++++++++++++++++++++
 tb/tb_uart_axil_bridge.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_axil_bridge_if.sv
// ============================================================================
// uart_axil_bridge_if
// AXI4-Lite slave bus bundle for the UART register-block bridge.
//
// Parameters
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  data width (32 only); STRB_WIDTH = DATA_WIDTH/8
//
// Signals (names seen from the slave side)
//   AW : s_awaddr_i, s_awvalid_i, s_awready_o
//   W  : s_wdata_i, s_wstrb_i, s_wvalid_i, s_wready_o
//   B  : s_bresp_o, s_bvalid_o, s_bready_i
//   AR : s_araddr_i, s_arvalid_i, s_arready_o
//   R  : s_rdata_o, s_rresp_o, s_rvalid_o, s_rready_i
//
// Modports
//   slave  - the bridge
//   master - the AXI requester driving the bridge
// ============================================================================
interface uart_axil_bridge_if #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] s_awaddr_i;
    logic                  s_awvalid_i;
    logic                  s_awready_o;

    logic [DATA_WIDTH-1:0] s_wdata_i;
    logic [STRB_WIDTH-1:0] s_wstrb_i;
    logic                  s_wvalid_i;
    logic                  s_wready_o;

    logic [1:0]            s_bresp_o;
    logic                  s_bvalid_o;
    logic                  s_bready_i;

    logic [ADDR_WIDTH-1:0] s_araddr_i;
    logic                  s_arvalid_i;
    logic                  s_arready_o;

    logic [DATA_WIDTH-1:0] s_rdata_o;
    logic [1:0]            s_rresp_o;
    logic                  s_rvalid_o;
    logic                  s_rready_i;

    modport slave (
        input  s_awaddr_i, s_awvalid_i,
        output s_awready_o,
        input  s_wdata_i, s_wstrb_i, s_wvalid_i,
        output s_wready_o,
        output s_bresp_o, s_bvalid_o,
        input  s_bready_i,
        input  s_araddr_i, s_arvalid_i,
        output s_arready_o,
        output s_rdata_o, s_rresp_o, s_rvalid_o,
        input  s_rready_i
    );

    modport master (
        output s_awaddr_i, s_awvalid_i,
        input  s_awready_o,
        output s_wdata_i, s_wstrb_i, s_wvalid_i,
        input  s_wready_o,
        input  s_bresp_o, s_bvalid_o,
        output s_bready_i,
        output s_araddr_i, s_arvalid_i,
        input  s_arready_o,
        input  s_rdata_o, s_rresp_o, s_rvalid_o,
        output s_rready_i
    );

endinterface

// File: rtl/uart_axil_bridge.sv
// ============================================================================
// uart_axil_bridge
// AXI4-Lite slave front end for the UART register block. Each AXI write or
// read becomes exactly one single-cycle mem_we_o / mem_re_o strobe; the
// register block's combinational response/data is captured and returned on
// B / R. Exactly one mem_re_o per AXI read, so RX FIFO pops never duplicate.
//
// Optional feature macro: UART_AXIL_STRB_CHECK_EN
//   defined   - partial-strobe writes are dropped (no mem_we_o) and get SLVERR
//   undefined - strobes are forwarded unchecked on mem_wstrb_o
//
// Ports
//   clk_i, arst_ni       clock, asynchronous active-low reset
//   s_axil               AXI4-Lite slave bus (uart_axil_bridge_if.slave)
//   mem_we_o             1-cycle write strobe
//   mem_waddr_o/wdata_o/wstrb_o   write address/data/strobes (hold between strobes)
//   mem_wresp_i          combinational write response (00 OKAY, 10 SLVERR)
//   mem_re_o, mem_raddr_o         1-cycle read strobe and address
//   mem_rdata_i, mem_rresp_i      combinational read data and response
// ============================================================================
module uart_axil_bridge #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        arst_ni,
    uart_axil_bridge_if.slave           s_axil,
    output logic                        mem_we_o,
    output logic [ADDR_WIDTH-1:0]       mem_waddr_o,
    output logic [DATA_WIDTH-1:0]       mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]     mem_wstrb_o,
    input  logic [1:0]                  mem_wresp_i,
    output logic                        mem_re_o,
    output logic [ADDR_WIDTH-1:0]       mem_raddr_o,
    input  logic [DATA_WIDTH-1:0]       mem_rdata_i,
    input  logic [1:0]                  mem_rresp_i
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    w_state_e              r_wstate;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_aw_held;
    logic                  r_w_held;
    logic                  r_werr;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_waddr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [STRB_WIDTH-1:0] r_mem_wstrb;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_done;
    logic                  w_w_done;
    logic [ADDR_WIDTH-1:0] w_awaddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [STRB_WIDTH-1:0] w_wstrb;
    logic                  w_wmisalign;
    logic                  w_wstrb_bad;
    logic                  w_werr;

    // Beats are either already held or completing their handshake this cycle.
    assign w_aw_hs   = r_awready & s_axil.s_awvalid_i;
    assign w_w_hs    = r_wready  & s_axil.s_wvalid_i;
    assign w_aw_done = r_aw_held | w_aw_hs;
    assign w_w_done  = r_w_held  | w_w_hs;

    // Bypass the holding registers so a same-cycle beat can issue immediately.
    assign w_awaddr  = r_aw_held ? r_awaddr : s_axil.s_awaddr_i;
    assign w_wdata   = r_w_held  ? r_wdata  : s_axil.s_wdata_i;
    assign w_wstrb   = r_w_held  ? r_wstrb  : s_axil.s_wstrb_i;

    assign w_wmisalign = (w_awaddr[1:0] != 2'b00);

`ifdef UART_AXIL_STRB_CHECK_EN
    assign w_wstrb_bad = (w_wstrb != {STRB_WIDTH{1'b1}});
`else
    assign w_wstrb_bad = 1'b0;
`endif

    assign w_werr = w_wmisalign | w_wstrb_bad;

    // Write FSM: collect AW and W, strobe once, return B.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_aw_held   <= 1'b0;
            r_w_held    <= 1'b0;
            r_werr      <= 1'b0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_bvalid    <= 1'b0;
            r_bresp     <= RESP_OKAY;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= s_axil.s_awaddr_i;
                        r_aw_held <= 1'b1;
                        r_awready <= 1'b0;
                    end else if (!r_aw_held) begin
                        r_awready <= 1'b1;
                    end

                    if (w_w_hs) begin
                        r_wdata  <= s_axil.s_wdata_i;
                        r_wstrb  <= s_axil.s_wstrb_i;
                        r_w_held <= 1'b1;
                        r_wready <= 1'b0;
                    end else if (!r_w_held) begin
                        r_wready <= 1'b1;
                    end

                    // Both beats in hand: strobe during the EXEC cycle.
                    if (w_aw_done && w_w_done) begin
                        r_wstate  <= W_EXEC;
                        r_werr    <= w_werr;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        if (!w_werr) begin
                            r_mem_we    <= 1'b1;
                            r_mem_waddr <= w_awaddr;
                            r_mem_wdata <= w_wdata;
                            r_mem_wstrb <= w_wstrb;
                        end
                    end
                end

                W_EXEC: begin
                    r_bresp  <= r_werr ? RESP_SLVERR : mem_wresp_i;
                    r_bvalid <= 1'b1;
                    r_wstate <= W_RESP;
                end

                W_RESP: begin
                    if (s_axil.s_bready_i) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end

                default: begin
                    r_wstate <= W_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_EXEC = 2'd1,
        R_RESP = 2'd2
    } r_state_e;

    r_state_e              r_rstate;
    logic                  r_arready;
    logic                  r_rerr;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_mem_re;
    logic [ADDR_WIDTH-1:0] r_mem_raddr;

    logic                  w_ar_hs;
    logic                  w_rmisalign;

    assign w_ar_hs     = r_arready & s_axil.s_arvalid_i;
    assign w_rmisalign = (s_axil.s_araddr_i[1:0] != 2'b00);

    // Read FSM: one AR -> one mem_re pulse -> one R beat.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rstate    <= R_IDLE;
            r_arready   <= 1'b0;
            r_rerr      <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rresp     <= RESP_OKAY;
            r_rdata     <= '0;
            r_mem_re    <= 1'b0;
            r_mem_raddr <= '0;
        end else begin
            r_mem_re <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rerr    <= w_rmisalign;
                        r_rstate  <= R_EXEC;
                        if (!w_rmisalign) begin
                            r_mem_re    <= 1'b1;
                            r_mem_raddr <= s_axil.s_araddr_i;
                        end
                    end else begin
                        r_arready <= 1'b1;
                    end
                end

                R_EXEC: begin
                    // Data only passes through on an OKAY response.
                    if (r_rerr) begin
                        r_rresp <= RESP_SLVERR;
                        r_rdata <= '0;
                    end else begin
                        r_rresp <= mem_rresp_i;
                        r_rdata <= (mem_rresp_i == RESP_OKAY) ? mem_rdata_i : '0;
                    end
                    r_rvalid <= 1'b1;
                    r_rstate <= R_RESP;
                end

                R_RESP: begin
                    if (s_axil.s_rready_i) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end

                default: begin
                    r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign s_axil.s_awready_o = r_awready;
    assign s_axil.s_wready_o  = r_wready;
    assign s_axil.s_bvalid_o  = r_bvalid;
    assign s_axil.s_bresp_o   = r_bresp;
    assign s_axil.s_arready_o = r_arready;
    assign s_axil.s_rvalid_o  = r_rvalid;
    assign s_axil.s_rresp_o   = r_rresp;
    assign s_axil.s_rdata_o   = r_rdata;

    assign mem_we_o    = r_mem_we;
    assign mem_waddr_o = r_mem_waddr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_wstrb_o = r_mem_wstrb;
    assign mem_re_o    = r_mem_re;
    assign mem_raddr_o = r_mem_raddr;

endmodule

// File: tb/tb_uart_axil_bridge.sv
// ============================================================================
// tb_uart_axil_bridge
// Scoreboarded bench for uart_axil_bridge. Expected mem strobes and AXI
// responses are queued when stimulus is issued and popped by monitors as the
// bridge produces them. Honours UART_AXIL_STRB_CHECK_EN like the design.
// ============================================================================
module tb_uart_axil_bridge;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    uart_axil_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axil ();

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [1:0]    stub_wresp = 2'b00;
    logic [1:0]    stub_rresp = 2'b00;
    logic [DW-1:0] stub_rdata = '0;

    uart_axil_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i       (clk),
        .arst_ni     (rst_n),
        .s_axil      (axil),
        .mem_we_o    (mem_we),
        .mem_waddr_o (mem_waddr),
        .mem_wdata_o (mem_wdata),
        .mem_wstrb_o (mem_wstrb),
        .mem_wresp_i (stub_wresp),
        .mem_re_o    (mem_re),
        .mem_raddr_o (mem_raddr),
        .mem_rdata_i (stub_rdata),
        .mem_rresp_i (stub_rresp)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int we_cnt = 0;
    int re_cnt = 0;

    logic [AW+DW+SW-1:0] exp_w_q[$];   // {addr, data, strb}
    logic [AW-1:0]       exp_ra_q[$];  // read address
    logic [1:0]          exp_b_q[$];   // bresp
    logic [DW+1:0]       exp_r_q[$];   // {rresp, rdata}

    // Scoreboard monitors: every strobe and every completed response pops one entry.
    always @(negedge clk) begin
        logic [AW+DW+SW-1:0] ew;
        logic [AW-1:0]       ea;
        logic [1:0]          eb;
        logic [DW+1:0]       er;
        if (mem_we) begin
            we_cnt++;
            n_cmp++;
            if (exp_w_q.size() == 0) begin
                n_err++;
                $display("FAIL mem_write: unexpected strobe addr=%h data=%h strb=%h, required none",
                         mem_waddr, mem_wdata, mem_wstrb);
            end else begin
                ew = exp_w_q.pop_front();
                if ({mem_waddr, mem_wdata, mem_wstrb} !== ew) begin
                    n_err++;
                    $display("FAIL mem_write: got %h required %h", {mem_waddr, mem_wdata, mem_wstrb}, ew);
                end
            end
        end
        if (mem_re) begin
            re_cnt++;
            n_cmp++;
            if (exp_ra_q.size() == 0) begin
                n_err++;
                $display("FAIL mem_read: unexpected strobe addr=%h, required none", mem_raddr);
            end else begin
                ea = exp_ra_q.pop_front();
                if (mem_raddr !== ea) begin
                    n_err++;
                    $display("FAIL mem_read: addr got %h required %h", mem_raddr, ea);
                end
            end
        end
        if (axil.s_bvalid_o && axil.s_bready_i) begin
            n_cmp++;
            if (exp_b_q.size() == 0) begin
                n_err++;
                $display("FAIL b_resp: unexpected bvalid bresp=%b, required none", axil.s_bresp_o);
            end else begin
                eb = exp_b_q.pop_front();
                if (axil.s_bresp_o !== eb) begin
                    n_err++;
                    $display("FAIL b_resp: got %b required %b", axil.s_bresp_o, eb);
                end
            end
        end
        if (axil.s_rvalid_o && axil.s_rready_i) begin
            n_cmp++;
            if (exp_r_q.size() == 0) begin
                n_err++;
                $display("FAIL r_resp: unexpected rvalid resp=%b data=%h, required none",
                         axil.s_rresp_o, axil.s_rdata_o);
            end else begin
                er = exp_r_q.pop_front();
                if ({axil.s_rresp_o, axil.s_rdata_o} !== er) begin
                    n_err++;
                    $display("FAIL r_resp: got %h required %h", {axil.s_rresp_o, axil.s_rdata_o}, er);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers: assert valid, wait (bounded) for ready, drop valid after the edge.
    // ------------------------------------------------------------------
    task automatic send_aw(input logic [AW-1:0] a);
        bit ok = 1'b0;
        axil.s_awaddr_i  = a;
        axil.s_awvalid_i = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (axil.s_awready_o) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        axil.s_awvalid_i = 1'b0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL aw_handshake: awready got 0 required 1 within 40 cycles"); end
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s);
        bit ok = 1'b0;
        axil.s_wdata_i  = d;
        axil.s_wstrb_i  = s;
        axil.s_wvalid_i = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (axil.s_wready_o) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        axil.s_wvalid_i = 1'b0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL w_handshake: wready got 0 required 1 within 40 cycles"); end
    endtask

    task automatic send_ar(input logic [AW-1:0] a);
        bit ok = 1'b0;
        axil.s_araddr_i  = a;
        axil.s_arvalid_i = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (axil.s_arready_o) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        axil.s_arvalid_i = 1'b0;
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL ar_handshake: arready got 0 required 1 within 40 cycles"); end
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            @(negedge clk);
            idle = (exp_w_q.size() == 0) && (exp_ra_q.size() == 0) && (exp_b_q.size() == 0) &&
                   (exp_r_q.size() == 0) && !axil.s_bvalid_o && !axil.s_rvalid_o;
        end
        n_cmp++;
        if (!idle) begin
            n_err++;
            $display("FAIL drain: pending w=%0d ra=%0d b=%0d r=%0d, required all 0",
                     exp_w_q.size(), exp_ra_q.size(), exp_b_q.size(), exp_r_q.size());
        end
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({axil.s_awready_o, axil.s_wready_o, axil.s_arready_o} !== 3'b000) begin
            n_err++; $display("FAIL reset_ready: got %b required 000",
                              {axil.s_awready_o, axil.s_wready_o, axil.s_arready_o});
        end
        n_cmp++;
        if ({axil.s_bvalid_o, axil.s_rvalid_o, mem_we, mem_re} !== 4'b0000) begin
            n_err++; $display("FAIL reset_valid: got %b required 0000",
                              {axil.s_bvalid_o, axil.s_rvalid_o, mem_we, mem_re});
        end
        n_cmp++;
        if ({axil.s_bresp_o, axil.s_rresp_o, axil.s_rdata_o, mem_waddr, mem_wdata, mem_wstrb, mem_raddr} !== '0) begin
            n_err++; $display("FAIL reset_data: got nonzero resp/data/addr, required all 0");
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({axil.s_awready_o, axil.s_wready_o, axil.s_arready_o} !== 3'b000) begin
            n_err++; $display("FAIL ready_before_first_clk: got %b required 000",
                              {axil.s_awready_o, axil.s_wready_o, axil.s_arready_o});
        end
        @(negedge clk);
        n_cmp++;
        if ({axil.s_awready_o, axil.s_wready_o, axil.s_arready_o} !== 3'b111) begin
            n_err++; $display("FAIL ready_after_first_clk: got %b required 111",
                              {axil.s_awready_o, axil.s_wready_o, axil.s_arready_o});
        end
    endtask

    task automatic test_write_same_cycle();
        @(posedge clk); #1;
        stub_wresp = 2'b00;
        exp_w_q.push_back({6'h08, 32'h0000_1234, 4'hF});
        exp_b_q.push_back(2'b00);
        fork
            send_aw(6'h08);
            send_w(32'h0000_1234, 4'hF);
        join
        @(negedge clk);   // cycle 1
        n_cmp++;
        if ({mem_we, axil.s_bvalid_o} !== 2'b10) begin
            n_err++; $display("FAIL wr_latency_c1: {we,bvalid} got %b required 10", {mem_we, axil.s_bvalid_o});
        end
        @(negedge clk);   // cycle 2
        n_cmp++;
        if ({mem_we, axil.s_bvalid_o} !== 2'b01) begin
            n_err++; $display("FAIL wr_latency_c2: {we,bvalid} got %b required 01", {mem_we, axil.s_bvalid_o});
        end
        @(negedge clk);   // cycle 3: back in idle with readies up
        n_cmp++;
        if ({axil.s_bvalid_o, axil.s_awready_o, axil.s_wready_o} !== 3'b011) begin
            n_err++; $display("FAIL wr_return_idle: {bvalid,awready,wready} got %b required 011",
                              {axil.s_bvalid_o, axil.s_awready_o, axil.s_wready_o});
        end
        wait_idle();
    endtask

    task automatic test_write_w_first();
        int we0;
        @(posedge clk); #1;
        stub_wresp = 2'b10;
        we0 = we_cnt;
        send_w(32'h0000_0041, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({axil.s_wready_o, mem_we, axil.s_awready_o} !== 3'b001) begin
                n_err++; $display("FAIL w_held_wait%0d: {wready,we,awready} got %b required 001", i,
                                  {axil.s_wready_o, mem_we, axil.s_awready_o});
            end
        end
        @(posedge clk); #1;
        exp_w_q.push_back({6'h14, 32'h0000_0041, 4'hF});
        exp_b_q.push_back(2'b10);
        send_aw(6'h14);
        wait_idle();
        n_cmp++;
        if (we_cnt - we0 !== 1) begin
            n_err++; $display("FAIL w_first_count: mem_we pulses got %0d required 1", we_cnt - we0);
        end
        stub_wresp = 2'b00;
    endtask

    task automatic test_read_backpressure();
        int re0;
        @(posedge clk); #1;
        stub_rresp = 2'b00;
        stub_rdata = 32'h0000_005A;
        axil.s_rready_i = 1'b0;
        exp_ra_q.push_back(6'h20);
        exp_r_q.push_back({2'b00, 32'h0000_005A});
        re0 = re_cnt;
        send_ar(6'h20);
        @(negedge clk);   // cycle 1
        n_cmp++;
        if ({mem_re, axil.s_rvalid_o} !== 2'b10) begin
            n_err++; $display("FAIL rd_latency_c1: {re,rvalid} got %b required 10", {mem_re, axil.s_rvalid_o});
        end
        // Upstream data changes after capture; R must keep the captured value.
        @(posedge clk); #1 stub_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({axil.s_rvalid_o, axil.s_arready_o, axil.s_rresp_o, axil.s_rdata_o} !==
                {1'b1, 1'b0, 2'b00, 32'h0000_005A}) begin
                n_err++; $display("FAIL rd_hold%0d: {rvalid,arready,rresp,rdata} got %h required %h", i,
                                  {axil.s_rvalid_o, axil.s_arready_o, axil.s_rresp_o, axil.s_rdata_o},
                                  {1'b1, 1'b0, 2'b00, 32'h0000_005A});
            end
        end
        @(posedge clk); #1 axil.s_rready_i = 1'b1;
        wait_idle();
        n_cmp++;
        if (re_cnt - re0 !== 1) begin
            n_err++; $display("FAIL rd_pop_count: mem_re pulses got %0d required 1", re_cnt - re0);
        end
    endtask

    task automatic test_misaligned();
        int re0;
        int we0;
        @(posedge clk); #1;
        stub_rresp = 2'b00;
        stub_rdata = 32'hDEAD_BEEF;
        stub_wresp = 2'b00;
        re0 = re_cnt;
        exp_r_q.push_back({2'b10, 32'h0000_0000});
        send_ar(6'h02);
        wait_idle();
        n_cmp++;
        if (re_cnt - re0 !== 0) begin
            n_err++; $display("FAIL misaligned_rd: mem_re pulses got %0d required 0", re_cnt - re0);
        end
        we0 = we_cnt;
        exp_b_q.push_back(2'b10);
        fork
            send_aw(6'h06);
            send_w(32'h0000_CAFE, 4'hF);
        join
        wait_idle();
        n_cmp++;
        if (we_cnt - we0 !== 0) begin
            n_err++; $display("FAIL misaligned_wr: mem_we pulses got %0d required 0", we_cnt - we0);
        end
    endtask

    task automatic test_concurrent();
        @(posedge clk); #1;
        stub_wresp = 2'b00;
        stub_rresp = 2'b00;
        stub_rdata = 32'h0000_00C3;
        exp_w_q.push_back({6'h00, 32'h0000_A5A5, 4'hF});
        exp_b_q.push_back(2'b00);
        exp_ra_q.push_back(6'h0C);
        exp_r_q.push_back({2'b00, 32'h0000_00C3});
        fork
            send_aw(6'h00);
            send_w(32'h0000_A5A5, 4'hF);
            send_ar(6'h0C);
        join
        @(negedge clk);
        n_cmp++;
        if ({mem_we, mem_re} !== 2'b11) begin
            n_err++; $display("FAIL concurrent_strobes: {we,re} got %b required 11", {mem_we, mem_re});
        end
        wait_idle();
    endtask

    task automatic test_strb();
        int we0;
        int exp_we;
        @(posedge clk); #1;
        stub_wresp = 2'b00;
        we0 = we_cnt;
`ifdef UART_AXIL_STRB_CHECK_EN
        exp_we = 0;
        exp_b_q.push_back(2'b10);
`else
        exp_we = 1;
        exp_w_q.push_back({6'h08, 32'h0000_BEEF, 4'h3});
        exp_b_q.push_back(2'b00);
`endif
        fork
            send_aw(6'h08);
            send_w(32'h0000_BEEF, 4'h3);
        join
        wait_idle();
        n_cmp++;
        if (we_cnt - we0 !== exp_we) begin
            n_err++; $display("FAIL strb_partial: mem_we pulses got %0d required %0d", we_cnt - we0, exp_we);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        @(posedge clk); #1;
        axil.s_bready_i = 1'b0;
        exp_w_q.push_back({6'h08, 32'h0000_0077, 4'hF});
        fork
            send_aw(6'h08);
            send_w(32'h0000_0077, 4'hF);
        join
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = axil.s_bvalid_o;
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL mid_bvalid: bvalid got 0 required 1 within 20 cycles"); end
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({axil.s_bvalid_o, axil.s_awready_o, axil.s_wready_o, mem_we} !== 4'b0000) begin
            n_err++; $display("FAIL mid_reset: {bvalid,awready,wready,we} got %b required 0000",
                              {axil.s_bvalid_o, axil.s_awready_o, axil.s_wready_o, mem_we});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        axil.s_bready_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({axil.s_awready_o, axil.s_wready_o, mem_we, mem_re} !== 4'b0000) begin
            n_err++; $display("FAIL post_reset_c0: {awready,wready,we,re} got %b required 0000",
                              {axil.s_awready_o, axil.s_wready_o, mem_we, mem_re});
        end
        @(posedge clk); #1;
        exp_w_q.push_back({6'h10, 32'h0000_0099, 4'hF});
        exp_b_q.push_back(2'b00);
        fork
            send_aw(6'h10);
            send_w(32'h0000_0099, 4'hF);
        join
        wait_idle();
    endtask

    initial begin
        axil.s_awaddr_i  = '0;
        axil.s_awvalid_i = 1'b0;
        axil.s_wdata_i   = '0;
        axil.s_wstrb_i   = '0;
        axil.s_wvalid_i  = 1'b0;
        axil.s_bready_i  = 1'b1;
        axil.s_araddr_i  = '0;
        axil.s_arvalid_i = 1'b0;
        axil.s_rready_i  = 1'b1;

        test_reset();
        test_write_same_cycle();
        test_write_w_first();
        test_read_backpressure();
        test_misaligned();
        test_concurrent();
        test_strb();
        test_reset_mid();

        n_cmp++;
        if (exp_w_q.size() + exp_ra_q.size() + exp_b_q.size() + exp_r_q.size() != 0) begin
            n_err++; $display("FAIL final_drain: pending entries got %0d required 0",
                              exp_w_q.size() + exp_ra_q.size() + exp_b_q.size() + exp_r_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
